address_decoder_programmable: RTL and testbench
===============================================

Name: address_decoder_programmable

Overview:
- Run-time programmable, multi-range successor to the static base/bound address decoder.
- Holds RANGE_COUNT independent base/bound register pairs, written through a config port.
- Compares each incoming address against all ranges in parallel and produces a registered hit vector, a lowest-index priority match and a multi-hit flag.
- Sits between an address source (e.g. the AGU) and the memory/I/O selects; the range map can change without resynthesis.

Parameters:
- ADDR_WIDTH, 10, width of addresses, bases and bounds (1..32).
- RANGE_COUNT, 4, number of independent ranges (1..32).
- RANGE_INDEX_WIDTH, 2, width of range index ports; must be >= clog2(RANGE_COUNT), minimum 1.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- cfg_wren  input  1  config write strobe.
- cfg_index  input  RANGE_INDEX_WIDTH  range selected for the config write.
- cfg_select  input  1  0 = write base, 1 = write bound.
- cfg_data  input  ADDR_WIDTH  value written to the selected base or bound.
- in_valid  input  1  lookup request valid.
- in_addr  input  ADDR_WIDTH  address to decode.
- out_valid  output  1  registered copy of in_valid.
- out_addr  output  ADDR_WIDTH  registered copy of in_addr.
- out_hit_vector  output  RANGE_COUNT  bit k set when base[k] <= addr <= bound[k].
- out_hit_any  output  1  OR of out_hit_vector.
- out_hit_index  output  RANGE_INDEX_WIDTH  lowest k with a hit; 0 when no hit.
- out_multi_hit  output  1  set when two or more ranges hit.

Behaviour:
- Comparison per range:
  - Hit when base[k] <= in_addr <= bound[k], unsigned and inclusive at both ends.
  - When base[k] > bound[k], the range is disabled and never hits.
- Latency is exactly 1 cycle:
  - The lookup presented at edge t appears on the out_* ports after edge t.
  - No backpressure; one lookup per cycle is accepted.
- When in_valid = 0:
  - out_valid goes to 0 the next cycle.
  - out_hit_vector, out_hit_any, out_hit_index and out_multi_hit are forced to 0.
  - out_addr still registers in_addr.
- Config write:
  - When cfg_wren = 1 and cfg_index < RANGE_COUNT, base or bound of range cfg_index takes cfg_data at the edge.
  - When cfg_index >= RANGE_COUNT, the write is silently ignored and no state changes.
- Write/lookup ordering:
  - A lookup in the same cycle as a config write uses the pre-write values.
  - The first lookup to see the new value is the one presented the cycle after the write.
- Base and bound are written separately:
  - Software programs a range by writing bound then base, or by disabling it first.
  - Transient mismatched pairs are legal and decode per the comparison rule.
- Priority:
  - out_hit_index is the lowest-numbered hitting range.
  - out_multi_hit = 1 when popcount(hit vector) >= 2.
  - Overlapping ranges are legal.
- Reset (synchronous, wins over cfg_wren and in_valid in the same cycle):
  - Every base is set to all-ones and every bound to 0, so all ranges are disabled.
  - All outputs go to 0.
  - After reset deasserts, a lookup sees only disabled ranges until programmed.
- Boundary cases that must decode correctly:
  - Single-address range (base = bound).
  - Full range (base = 0, bound = 2^ADDR_WIDTH-1).
  - Address 0 and the maximum address.
  - No overflow or wrap: a range never wraps past the maximum address.
- Sequential elements:
  - RANGE_COUNT x 2 x ADDR_WIDTH config registers.
  - One output pipeline register stage.
  - No other state.

Test Plan:
- Reset, then lookups at 0x000 and 0x3FF with in_valid = 1 -> out_valid = 1, hit_vector = 0, hit_any = 0, hit_index = 0, multi_hit = 0, one cycle later.
- Program r0 = 0x100..0x1FF and r1 = 0x180..0x27F, then look up 0x0FF, 0x100, 0x180, 0x1FF, 0x200, 0x27F, 0x280 -> hit_vector 0000, 0001, 0011, 0011, 0010, 0010, 0000; multi_hit = 1 only at 0x180 and 0x1FF; hit_index = 0 when both hit.
- Write r2 bound = 0x050 while looking up 0x050 in the same cycle (r2 base = 0x050 already written) -> that lookup misses; the lookup of 0x050 next cycle hits with hit_index = 2.
- cfg_index = 5 with RANGE_INDEX_WIDTH = 3 and RANGE_COUNT = 4 -> no range changes; subsequent lookups are unchanged.
- r3 = 0x000..0x3FF and r3 = 0x3FF..0x3FF; sweep every address -> full range hits all addresses; single range hits only 0x3FF; in_valid = 0 cycles give all-zero hit outputs.
- Assert reset mid-stream with cfg_wren = 1 and in_valid = 1 -> the next cycle has all outputs 0 and all ranges disabled; the write is discarded.

Source files
------------

// File: rtl/address_decoder_programmable.sv
// Run-time programmable multi-range address decoder: RANGE_COUNT base/bound pairs,
// compared in parallel against each lookup, with a one-cycle registered result.
module address_decoder_programmable #(
    parameter int ADDR_WIDTH        = 10,
    parameter int RANGE_COUNT       = 4,
    parameter int RANGE_INDEX_WIDTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cfg_wren,
    input  logic [RANGE_INDEX_WIDTH-1:0] cfg_index,
    input  logic                         cfg_select,
    input  logic [ADDR_WIDTH-1:0]        cfg_data,
    input  logic                         in_valid,
    input  logic [ADDR_WIDTH-1:0]        in_addr,
    output logic                         out_valid,
    output logic [ADDR_WIDTH-1:0]        out_addr,
    output logic [RANGE_COUNT-1:0]       out_hit_vector,
    output logic                         out_hit_any,
    output logic [RANGE_INDEX_WIDTH-1:0] out_hit_index,
    output logic                         out_multi_hit
);

    logic [ADDR_WIDTH-1:0]        base_regs  [RANGE_COUNT];
    logic [ADDR_WIDTH-1:0]        bound_regs [RANGE_COUNT];
    logic [RANGE_COUNT-1:0]       hit_vector;
    logic [RANGE_INDEX_WIDTH-1:0] hit_index;
    logic                         multi_hit;

    // NOTE: the range registers are reset even though they form a small register file,
    // because the post-reset map must decode as all-disabled (base > bound).
    // Indices that match no range (>= RANGE_COUNT) simply select nothing.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < RANGE_COUNT; k++) begin
                base_regs[k]  <= '1;
                bound_regs[k] <= '0;
            end
        end else if (cfg_wren) begin
            for (int k = 0; k < RANGE_COUNT; k++) begin
                if (cfg_index == RANGE_INDEX_WIDTH'(k)) begin
                    if (cfg_select) bound_regs[k] <= cfg_data;
                    else            base_regs[k]  <= cfg_data;
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        hit_vector = '0;
        hit_index  = '0;
        // A disabled range (base > bound) has no address satisfying both compares.
        for (int k = 0; k < RANGE_COUNT; k++) begin
            hit_vector[k] = in_valid && (in_addr >= base_regs[k]) && (in_addr <= bound_regs[k]);
        end
        // Scan downward so the lowest-numbered hitting range is the last to assign.
        for (int k = RANGE_COUNT - 1; k >= 0; k--) begin
            if (hit_vector[k]) hit_index = RANGE_INDEX_WIDTH'(k);
        end
    end

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign multi_hit = |(hit_vector & (hit_vector - RANGE_COUNT'(1)));

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, which is what gives lookups the pre-write range map.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_addr       <= '0;
            out_hit_vector <= '0;
            out_hit_any    <= 1'b0;
            out_hit_index  <= '0;
            out_multi_hit  <= 1'b0;
        end else begin
            out_valid      <= in_valid;
            out_addr       <= in_addr;
            out_hit_vector <= hit_vector;
            out_hit_any    <= |hit_vector;
            out_hit_index  <= hit_index;
            out_multi_hit  <= multi_hit;
        end
    end

endmodule

// File: tb/tb_address_decoder_programmable.sv
// Directed, table-driven bench for address_decoder_programmable with a shadow range
// map for the full-address sweeps.
module tb_address_decoder_programmable;

    localparam int AW = 10;
    localparam int RC = 4;
    localparam int IW = 3;
    localparam int PW = 1 + AW + RC + 1 + IW + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          cfg_wren;
    logic [IW-1:0] cfg_index;
    logic          cfg_select;
    logic [AW-1:0] cfg_data;
    logic          in_valid;
    logic [AW-1:0] in_addr;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [RC-1:0] out_hit_vector;
    logic          out_hit_any;
    logic [IW-1:0] out_hit_index;
    logic          out_multi_hit;

    address_decoder_programmable #(
        .ADDR_WIDTH(AW), .RANGE_COUNT(RC), .RANGE_INDEX_WIDTH(IW)
    ) dut (
        .clock(clock), .reset(reset),
        .cfg_wren(cfg_wren), .cfg_index(cfg_index), .cfg_select(cfg_select), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_addr(in_addr),
        .out_valid(out_valid), .out_addr(out_addr), .out_hit_vector(out_hit_vector),
        .out_hit_any(out_hit_any), .out_hit_index(out_hit_index), .out_multi_hit(out_multi_hit)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] base_m  [RC];
    logic [AW-1:0] bound_m [RC];

    typedef struct {
        logic [AW-1:0] addr;
        logic [RC-1:0] vec;
        logic [IW-1:0] idx;
        logic          multi;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [PW-1:0] pack(input logic v, input logic [AW-1:0] a,
                                           input logic [RC-1:0] vec, input logic any,
                                           input logic [IW-1:0] idx, input logic multi);
        return {v, a, vec, any, idx, multi};
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {valid,addr,vec,any,idx,multi}=%h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [PW-1:0] dut_out();
        return pack(out_valid, out_addr, out_hit_vector, out_hit_any, out_hit_index, out_multi_hit);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < RC; k++) begin
            base_m[k]  = '1;
            bound_m[k] = '0;
        end
    endtask

    task automatic cfg_write(input logic [IW-1:0] idx, input logic sel, input logic [AW-1:0] data);
        cfg_wren   = 1'b1;
        cfg_index  = idx;
        cfg_select = sel;
        cfg_data   = data;
        in_valid   = 1'b0;
        tick();
        cfg_wren = 1'b0;
        if (int'(idx) < RC) begin
            if (sel) bound_m[int'(idx)] = data;
            else     base_m[int'(idx)]  = data;
        end
    endtask

    // One lookup with hand-supplied expected hit vector, index and multi flag.
    task automatic lookup(input string name, input logic [AW-1:0] a, input logic v,
                          input logic [RC-1:0] vec, input logic [IW-1:0] idx, input logic multi);
        in_addr  = a;
        in_valid = v;
        tick();
        check(name, dut_out(), v ? pack(1'b1, a, vec, |vec, idx, multi) : pack(1'b0, a, '0, 1'b0, '0, 1'b0));
    endtask

    // One lookup whose expectation comes from the shadow range map.
    task automatic lookup_model(input string name, input logic [AW-1:0] a, input logic v);
        logic [RC-1:0] vec;
        logic [IW-1:0] idx;
        int            cnt;
        vec = '0;
        idx = '0;
        cnt = 0;
        for (int k = 0; k < RC; k++) begin
            if (base_m[k] <= a && a <= bound_m[k]) begin
                if (cnt == 0) idx = IW'(k);
                vec[k] = 1'b1;
                cnt++;
            end
        end
        lookup(name, a, v, vec, idx, cnt >= 2);
    endtask

    initial begin
        tbl[0] = '{addr: 10'h0FF, vec: 4'b0000, idx: 3'd0, multi: 1'b0};
        tbl[1] = '{addr: 10'h100, vec: 4'b0001, idx: 3'd0, multi: 1'b0};
        tbl[2] = '{addr: 10'h180, vec: 4'b0011, idx: 3'd0, multi: 1'b1};
        tbl[3] = '{addr: 10'h1FF, vec: 4'b0011, idx: 3'd0, multi: 1'b1};
        tbl[4] = '{addr: 10'h200, vec: 4'b0010, idx: 3'd1, multi: 1'b0};
        tbl[5] = '{addr: 10'h27F, vec: 4'b0010, idx: 3'd1, multi: 1'b0};
        tbl[6] = '{addr: 10'h280, vec: 4'b0000, idx: 3'd0, multi: 1'b0};

        model_reset();
        reset      = 1'b1;
        cfg_wren   = 1'b0;
        cfg_index  = '0;
        cfg_select = 1'b0;
        cfg_data   = '0;
        in_valid   = 1'b1;
        in_addr    = 10'h3FF;
        tick();
        tick();
        check("reset_state", dut_out(), '0);
        reset = 1'b0;

        // Freshly reset map: every range disabled.
        lookup("post_reset_0x000", 10'h000, 1'b1, 4'b0000, 3'd0, 1'b0);
        lookup("post_reset_0x3FF", 10'h3FF, 1'b1, 4'b0000, 3'd0, 1'b0);

        cfg_write(3'd0, 1'b1, 10'h1FF);
        cfg_write(3'd0, 1'b0, 10'h100);
        cfg_write(3'd1, 1'b1, 10'h27F);
        cfg_write(3'd1, 1'b0, 10'h180);
        for (int i = 0; i < 7; i++) begin
            lookup($sformatf("overlap_%0h", tbl[i].addr), tbl[i].addr, 1'b1, tbl[i].vec, tbl[i].idx, tbl[i].multi);
        end

        // r2 base first (still disabled), then bound written alongside a lookup.
        cfg_write(3'd2, 1'b0, 10'h050);
        lookup("r2_base_only", 10'h050, 1'b1, 4'b0000, 3'd0, 1'b0);
        cfg_wren   = 1'b1;
        cfg_index  = 3'd2;
        cfg_select = 1'b1;
        cfg_data   = 10'h050;
        in_valid   = 1'b1;
        in_addr    = 10'h050;
        tick();
        cfg_wren   = 1'b0;
        bound_m[2] = 10'h050;
        check("same_cycle_write_miss", dut_out(), pack(1'b1, 10'h050, 4'b0000, 1'b0, 3'd0, 1'b0));
        lookup("next_cycle_hit", 10'h050, 1'b1, 4'b0100, 3'd2, 1'b0);

        // Out-of-range indices must not alias onto a real range.
        cfg_write(3'd5, 1'b0, 10'h000);
        cfg_write(3'd7, 1'b1, 10'h3FF);
        lookup("oob_0x050", 10'h050, 1'b1, 4'b0100, 3'd2, 1'b0);
        lookup("oob_0x000", 10'h000, 1'b1, 4'b0000, 3'd0, 1'b0);
        lookup("oob_0x3FF", 10'h3FF, 1'b1, 4'b0000, 3'd0, 1'b0);
        lookup("oob_0x1FF", 10'h1FF, 1'b1, 4'b0011, 3'd0, 1'b1);

        // Full range on r3, then narrowed to the single top address.
        cfg_write(3'd3, 1'b1, 10'h3FF);
        cfg_write(3'd3, 1'b0, 10'h000);
        lookup("full_0x000", 10'h000, 1'b1, 4'b1000, 3'd3, 1'b0);
        lookup("full_0x3FF", 10'h3FF, 1'b1, 4'b1000, 3'd3, 1'b0);
        lookup("full_0x180", 10'h180, 1'b1, 4'b1011, 3'd0, 1'b1);
        for (int a = 0; a < (1 << AW); a++) begin
            lookup_model($sformatf("full_sweep_%0h", a), AW'(a), (a % 7) != 3);
        end

        cfg_write(3'd3, 1'b0, 10'h3FF);
        lookup("single_0x3FF", 10'h3FF, 1'b1, 4'b1000, 3'd3, 1'b0);
        lookup("single_0x3FE", 10'h3FE, 1'b1, 4'b0000, 3'd0, 1'b0);
        lookup("single_idle", 10'h3FF, 1'b0, 4'b0000, 3'd0, 1'b0);
        for (int a = 0; a < (1 << AW); a++) begin
            lookup_model($sformatf("single_sweep_%0h", a), AW'(a), (a % 5) != 2);
        end

        // Reset beats a simultaneous write and lookup.
        reset      = 1'b1;
        cfg_wren   = 1'b1;
        cfg_index  = 3'd0;
        cfg_select = 1'b0;
        cfg_data   = 10'h000;
        in_valid   = 1'b1;
        in_addr    = 10'h150;
        tick();
        check("mid_reset_outputs", dut_out(), '0);
        reset    = 1'b0;
        cfg_wren = 1'b0;
        model_reset();
        lookup("after_reset_0x150", 10'h150, 1'b1, 4'b0000, 3'd0, 1'b0);
        lookup("after_reset_0x000", 10'h000, 1'b1, 4'b0000, 3'd0, 1'b0);
        lookup("after_reset_0x3FF", 10'h3FF, 1'b1, 4'b0000, 3'd0, 1'b0);
        lookup("after_reset_0x050", 10'h050, 1'b1, 4'b0000, 3'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
